fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32, word-aligned fetch address.
REQ-006 SHALL have port imem_ack, input, 1, one-cycle pulse: imem_rdata is valid.
REQ-007 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-008 SHALL have ports instr (output, 32, held instruction), opcode (output, 6, instr[31:26]) and funct (output, 6, instr[5:0]), feeding the control unit.
REQ-009 SHALL have port instr_valid, output, 1, instr/opcode/funct are stable and valid.
REQ-010 SHALL have port pc, output, 32, address of the held instruction; port pc_plus4, output, 32, pc+4 for jal link.
REQ-011 SHALL have port exec_done, input, 1, one-cycle pulse: datapath has resolved the held instruction.
REQ-012 SHALL have ports pc_src (input, 2), branch (input, 1), cond_zero (input, 1), alu_zero (input, 1), jr_target (input, 32), sampled only when exec_done=1.
REQ-013 SHALL have port addr_err, output, 1, one-cycle pulse: jr_target was not word-aligned.

Function
REQ-014 SHALL implement FSM states FETCH, WAIT_ACK and HOLD.
REQ-015 In FETCH, imem_req=1 and imem_addr=fetch_pc for exactly one cycle, then the FSM SHALL enter WAIT_ACK.
REQ-016 In WAIT_ACK, imem_req=0; on imem_ack=1, the unit SHALL latch imem_rdata into instr, set pc=fetch_pc, assert instr_valid from the next cycle and enter HOLD.
REQ-017 WAIT_ACK SHALL wait indefinitely with no timeout; imem_ack outside WAIT_ACK SHALL be ignored.
REQ-018 In HOLD, instr, pc and instr_valid SHALL stay constant until exec_done=1.
REQ-019 On exec_done=1 in HOLD, the unit SHALL compute the next fetch_pc, clear instr_valid the next cycle and enter FETCH. exec_done outside HOLD SHALL be ignored.
REQ-020 Next-PC, pc_src=2'b01 (j/jal): {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-021 Next-PC, pc_src=2'b10 (jr): {jr_target[31:2], 2'b00}; addr_err SHALL pulse for one cycle if jr_target[1:0]!=0.
REQ-022 Next-PC, pc_src=2'b00: if branch=1 and alu_zero==cond_zero, the result is pc_plus4 + (sign-extended instr[15:0] << 2); otherwise it is pc_plus4. This covers beq with cond_zero=1 and bne with cond_zero=0.
REQ-023 Next-PC, pc_src=2'b11: pc_plus4.
REQ-024 All address arithmetic SHALL be 32-bit modulo 2^32: 32'hFFFF_FFFC+4 wraps to 32'h0, and backward branches wrap likewise.
REQ-025 Minimum instruction period: FETCH(1) + WAIT_ACK(>=1) + HOLD(>=1) = 3 cycles.

Reset
REQ-026 While reset=1, the unit SHALL be in FETCH with fetch_pc=RESET_PC, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0 and addr_err=0.
REQ-027 After reset falls, the first rising clk edge SHALL begin the FETCH cycle for RESET_PC.
REQ-028 Reset asserted mid-WAIT_ACK or mid-HOLD SHALL abort immediately; an imem_ack arriving after reset falls SHALL be ignored unless the unit is in WAIT_ACK.

Verification
REQ-029 Reset release, mem acks 2 cycles after req with 32'h2409_0005 -> imem_addr=0, instr_valid=1, opcode=6'h09, pc=0.
REQ-030 Held beq at pc=32'h10, imm=16'hFFFC, branch=1, cond_zero=1, alu_zero=1, exec_done -> next imem_addr=32'h04; same inputs with alu_zero=0 -> imem_addr=32'h14.
REQ-031 bne at pc=32'h20, imm=3, cond_zero=0, alu_zero=0 -> next imem_addr=32'h30.
REQ-032 jal at pc=32'h1000_0040, instr[25:0]=26'h0000100, pc_src=01 -> imem_addr=32'h1000_0400, pc_plus4=32'h1000_0044 during HOLD.
REQ-033 jr with jr_target=32'h0000_0102, pc_src=10 -> imem_addr=32'h100 and a single addr_err pulse.
REQ-034 Reset pulse in WAIT_ACK, then a stale imem_ack -> ack ignored, next fetch at RESET_PC, instr_valid=0 until the fresh ack.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM (FETCH -> WAIT_ACK -> HOLD) with next-PC selection.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   imem_req/imem_addr    one-cycle read request and word-aligned fetch address
//   imem_ack/imem_rdata   one-cycle read acknowledge and returned instruction word
//   instr/opcode/funct    held instruction and its decoded fields; instr_valid qualifies them
//   pc/pc_plus4           address of the held instruction and its link address
//   exec_done             held instruction resolved; pc_src/branch/cond_zero/alu_zero/jr_target sampled then
//   addr_err              one-cycle pulse on a misaligned jr target
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        exec_done,
    input  logic [1:0]  pc_src,
    input  logic        branch,
    input  logic        cond_zero,
    input  logic        alu_zero,
    input  logic [31:0] jr_target,
    output logic        addr_err
);
    typedef enum logic [1:0] {FETCH, WAIT_ACK, HOLD} state_t;
    state_t      state_q;
    logic        req_q;
    logic        valid_q;
    logic        addr_err_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] fetch_pc_d;
    logic [31:0] br_off;
    logic        taken;
    assign pc_plus4    = pc_q + 32'd4;
    assign br_off      = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign taken       = branch && (alu_zero == cond_zero);
    always_comb begin
        fetch_pc_d = pc_plus4;
        fetch_pc_d = (pc_src == 2'b01) ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
                     (pc_src == 2'b10) ? {jr_target[31:2], 2'b00} :
                     (pc_src == 2'b00 && taken) ? pc_plus4 + br_off : pc_plus4;
    end
    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign addr_err    = addr_err_q;
    // req_q stays low during reset; the first edge after release raises it, so the
    // request cycle of FETCH is always exactly one cycle long.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            addr_err_q <= 1'b0;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
        end else begin
            addr_err_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    req_q <= ~req_q;
                    if (req_q) state_q <= WAIT_ACK;
                end
                WAIT_ACK: if (imem_ack) begin
                    instr_q <= imem_rdata;
                    pc_q    <= fetch_pc_q;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: if (exec_done) begin
                    fetch_pc_q <= fetch_pc_d;
                    valid_q    <= 1'b0;
                    req_q      <= 1'b1;
                    addr_err_q <= (pc_src == 2'b10) && (jr_target[1:0] != 2'b00);
                    state_q    <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: instruction-level reference model check of fetch_unit with directed and random programs.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic        branch = 1'b0;
    logic        cond_zero = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic        addr_err;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
        .funct(funct), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .exec_done(exec_done), .pc_src(pc_src), .branch(branch), .cond_zero(cond_zero),
        .alu_zero(alu_zero), .jr_target(jr_target), .addr_err(addr_err)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] d,
                                             input logic [1:0] s, input logic br, cz, az,
                                             input logic [31:0] jr);
        logic [31:0] p4;
        logic [31:0] off;
        p4  = p + 32'd4;
        off = 32'($signed(d[15:0])) * 32'd4;
        if (s == 2'd1) return (p4 & 32'hF000_0000) | ((d & 32'h03FF_FFFF) * 32'd4);
        if (s == 2'd2) return jr & 32'hFFFF_FFFC;
        if (s == 2'd0 && br && (az == cz)) return p4 + off;
        return p4;
    endfunction
    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_err", {31'b0, addr_err}, 32'd0);
        reset = 1'b0;
        m_pc = 32'h0;
    endtask
    // Runs one complete instruction: fetch, acknowledge after ack_dly extra cycles,
    // hold for hold_dly cycles, then resolve it with the given control inputs.
    task automatic do_instr(input logic [31:0] d, input logic [1:0] s, input logic br, cz, az,
                            input logic [31:0] jr, input int ack_dly, input int hold_dly,
                            input bit noise);
        int n;
        logic [31:0] nxt;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req", {31'b0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, m_pc);
        imem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_rdata = $urandom;
        @(negedge clk);
        check("req_drop", {31'b0, imem_req}, 32'd0);
        check("err_clear", {31'b0, addr_err}, 32'd0);
        imem_ack = 1'b0;
        repeat (ack_dly) begin
            exec_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check("wait_valid", {31'b0, instr_valid}, 32'd0);
        end
        exec_done  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = d;
        @(negedge clk);
        imem_ack = 1'b0;
        check("valid", {31'b0, instr_valid}, 32'd1);
        check("instr", instr, d);
        check("opcode", {26'b0, opcode}, {26'b0, d[31:26]});
        check("funct", {26'b0, funct}, {26'b0, d[5:0]});
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        repeat (hold_dly) begin
            imem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            check("hold_valid", {31'b0, instr_valid}, 32'd1);
            check("hold_instr", instr, d);
            check("hold_pc", pc, m_pc);
        end
        imem_ack  = 1'b0;
        exec_done = 1'b1;
        pc_src    = s;
        branch    = br;
        cond_zero = cz;
        alu_zero  = az;
        jr_target = jr;
        nxt = ref_next(m_pc, d, s, br, cz, az, jr);
        @(negedge clk);
        exec_done = 1'b0;
        pc_src    = 2'($urandom);
        jr_target = $urandom;
        check("done_valid", {31'b0, instr_valid}, 32'd0);
        check("addr_err", {31'b0, addr_err}, {31'b0, (s == 2'd2) && (jr % 4 != 0)});
        check("next_addr", imem_addr, nxt);
        m_pc = nxt;
    endtask
    initial begin
        apply_reset();
        @(negedge clk);
        do_instr(32'h2409_0005, 2'd3, 0, 0, 0, 0, 0, 0, 0);
        check("r029_addr", imem_addr, 32'h4);
        do_instr($urandom, 2'd2, 0, 0, 0, 32'h10, 1, 1, 0);
        do_instr(32'h1000_FFFC, 2'd0, 1, 1, 1, 0, 0, 2, 0);
        check("beq_taken", imem_addr, 32'h04);
        do_instr($urandom, 2'd2, 0, 0, 0, 32'h10, 0, 0, 0);
        do_instr(32'h1000_FFFC, 2'd0, 1, 1, 0, 0, 2, 0, 0);
        check("beq_not", imem_addr, 32'h14);
        do_instr($urandom, 2'd2, 0, 0, 0, 32'h20, 0, 0, 0);
        do_instr(32'h1400_0003, 2'd0, 1, 0, 0, 0, 1, 0, 0);
        check("bne_taken", imem_addr, 32'h30);
        do_instr($urandom, 2'd2, 0, 0, 0, 32'h1000_0040, 0, 0, 0);
        do_instr(32'h0C00_0100, 2'd1, 0, 0, 0, 0, 0, 1, 0);
        check("jal_addr", imem_addr, 32'h1000_0400);
        do_instr($urandom, 2'd2, 0, 0, 0, 32'h0000_0102, 0, 0, 0);
        check("jr_addr", imem_addr, 32'h100);
        do_instr($urandom, 2'd2, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
        do_instr($urandom, 2'd3, 0, 0, 0, 0, 0, 0, 0);
        check("wrap_addr", imem_addr, 32'h0);
        do_instr(32'h1000_FFFE, 2'd0, 1, 1, 1, 0, 0, 0, 0);
        check("back_wrap", imem_addr, 32'hFFFF_FFFC);
        // Reset during WAIT_ACK followed by a stale acknowledge.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_valid", {31'b0, instr_valid}, 32'd0);
        check("abort_req", {31'b0, imem_req}, 32'd0);
        check("abort_addr", imem_addr, 32'h0);
        @(negedge clk);
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check("stale_valid", {31'b0, instr_valid}, 32'd0);
        check("stale_instr", instr, 32'h0);
        check("stale_req", {31'b0, imem_req}, 32'd1);
        m_pc = 32'h0;
        do_instr(32'h2409_0005, 2'd3, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++)
            do_instr($urandom, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
